// File: rtl/wb_spi_cfg_pkg.sv
// Shared register map, FSM encoding and CTRL field layout for the SPI config writer.
package wb_spi_cfg_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_TX     = 2'd1;
  localparam logic [1:0] REG_RX     = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_HIGH,
    ST_LOW
  } spi_state_e;

  typedef struct packed {
    logic [7:0] ss_mask;
    logic [5:0] nbits;
  } ctrl_t;

  // A zero or oversized bit count means a full 32-bit frame.
  function automatic logic [5:0] norm_nbits(input logic [5:0] raw);
    return (raw == 6'd0 || raw > 6'd32) ? 6'd32 : raw;
  endfunction

endpackage

// File: rtl/spi_shift_core.sv
// SPI mode-0 MSB-first shifter: busy rises the cycle after start and lasts CLK_DIV*(2n+1) clocks.
// No backpressure; start is ignored unless idle, so the caller gates it on busy.
module spi_shift_core
  import wb_spi_cfg_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int NUM_SS  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [5:0]        nbits,
  input  logic [NUM_SS-1:0] ss_mask,
  input  logic [31:0]       tx,
  output logic              busy,
  output logic [31:0]       rx,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_SS-1:0] ss_n
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  spi_state_e  state;
  logic [7:0]  div_cnt;
  logic [5:0]  bits_left;
  logic [31:0] tx_sh;
  logic [31:0] rx_sh;
  logic [5:0]  n_eff;
  logic [31:0] tx_aligned;

  assign n_eff      = norm_nbits(nbits);
  // Left-justify the frame so the first bit out is always tx_sh[31].
  assign tx_aligned = tx << (6'd32 - n_eff);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      div_cnt   <= '0;
      bits_left <= '0;
      tx_sh     <= '0;
      rx_sh     <= '0;
      rx        <= '0;
      busy      <= 1'b0;
      sclk      <= 1'b0;
      mosi      <= 1'b0;
      ss_n      <= '1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_SETUP;
            div_cnt   <= DIV_LAST;
            bits_left <= n_eff;
            tx_sh     <= tx_aligned;
            rx_sh     <= '0;
            busy      <= 1'b1;
            ss_n      <= ~ss_mask;
            mosi      <= tx_aligned[31];
          end
        end
        ST_SETUP: begin
          if (div_cnt == 8'd0) begin
            state   <= ST_HIGH;
            div_cnt <= DIV_LAST;
            sclk    <= 1'b1;
            rx_sh   <= {rx_sh[30:0], miso};
          end else begin
            div_cnt <= div_cnt - 8'd1;
          end
        end
        ST_HIGH: begin
          if (div_cnt == 8'd0) begin
            state     <= ST_LOW;
            div_cnt   <= DIV_LAST;
            sclk      <= 1'b0;
            bits_left <= bits_left - 6'd1;
            tx_sh     <= tx_sh << 1;
            mosi      <= tx_sh[30];
          end else begin
            div_cnt <= div_cnt - 8'd1;
          end
        end
        ST_LOW: begin
          if (div_cnt == 8'd0) begin
            div_cnt <= DIV_LAST;
            if (bits_left == 6'd0) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
              ss_n  <= '1;
              mosi  <= 1'b0;
              rx    <= rx_sh;
            end else begin
              state <= ST_HIGH;
              sclk  <= 1'b1;
              rx_sh <= {rx_sh[30:0], miso};
            end
          end else begin
            div_cnt <= div_cnt - 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/wb_spi_cfg_writer.sv
// Wishbone-to-SPI config writer: registered 1-cycle ack, read data valid in the ack cycle.
// A TX write while busy is stalled (no ack) until the current frame completes.
module wb_spi_cfg_writer
  import wb_spi_cfg_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int NUM_SS  = 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [15:0]       wb_adr_i,
  input  logic [3:0]        wb_sel_i,
  input  logic [31:0]       wb_dat_i,
  output logic [31:0]       wb_dat_o,
  output logic              wb_ack_o,
  output logic              sclk_o,
  output logic              mosi_o,
  input  logic              miso_i,
  output logic [NUM_SS-1:0] ss_n_o,
  output logic              busy_o
);

  ctrl_t       ctrl_q;
  logic [31:0] tx_q;
  logic [31:0] tx_next;
  logic [31:0] rx;
  logic [31:0] rd_dat;
  logic [1:0]  reg_sel;
  logic        busy;
  logic        req;
  logic        accept;
  logic        wr;
  logic        start;
  logic        unused_bits;

  assign reg_sel = wb_adr_i[3:2];
  assign req     = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  // Holding the ack on a busy TX write is what paces the upstream ROM writer.
  assign accept  = req & ~(wb_we_i & (reg_sel == REG_TX) & busy);
  assign wr      = accept & wb_we_i;
  assign start   = wr & (reg_sel == REG_TX) & (|wb_sel_i);
  assign busy_o  = busy;

  assign unused_bits = ^{wb_adr_i[15:4], wb_adr_i[1:0], ctrl_q.ss_mask};

  always_comb begin
    tx_next = tx_q;
    for (int b = 0; b < 4; b++) begin
      if (wb_sel_i[b]) tx_next[8*b +: 8] = wb_dat_i[8*b +: 8];
    end
  end

  always_comb begin
    rd_dat = '0;
    case (reg_sel)
      REG_CTRL:   rd_dat = {16'h0000, ctrl_q.ss_mask, 2'b00, ctrl_q.nbits};
      REG_RX:     rd_dat = rx;
      REG_STATUS: rd_dat = {31'd0, busy};
      default:    rd_dat = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      ctrl_q   <= '0;
      tx_q     <= '0;
    end else begin
      wb_ack_o <= accept;
      wb_dat_o <= (accept & ~wb_we_i) ? rd_dat : '0;
      if (wr && reg_sel == REG_CTRL) begin
        if (wb_sel_i[0]) ctrl_q.nbits   <= wb_dat_i[5:0];
        if (wb_sel_i[1]) ctrl_q.ss_mask <= wb_dat_i[15:8];
      end
      if (wr && reg_sel == REG_TX) tx_q <= tx_next;
    end
  end

  spi_shift_core #(
    .CLK_DIV (CLK_DIV),
    .NUM_SS  (NUM_SS)
  ) u_core (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_ni),
    .start   (start),
    .nbits   (ctrl_q.nbits),
    .ss_mask (ctrl_q.ss_mask[NUM_SS-1:0]),
    .tx      (tx_next),
    .busy    (busy),
    .rx      (rx),
    .sclk    (sclk_o),
    .mosi    (mosi_o),
    .miso    (miso_i),
    .ss_n    (ss_n_o)
  );

endmodule

// File: tb/tb_wb_spi_cfg_writer.sv
// Bench for wb_spi_cfg_writer: frame-level reference model plus directed and random bus traffic.
`timescale 1ns/1ps
module tb_wb_spi_cfg_writer;

  localparam int D   = 2;
  localparam int NSS = 8;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b1;
  logic           cyc   = 1'b0;
  logic           stb   = 1'b0;
  logic           we    = 1'b0;
  logic [15:0]    adr   = '0;
  logic [3:0]     sel   = '0;
  logic [31:0]    dat_w = '0;
  logic           miso  = 1'b0;
  logic [31:0]    dat_r;
  logic           ack, sclk, mosi, busy;
  logic [NSS-1:0] ss_n;

  int checks = 0;
  int errors = 0;
  int cyc_no = 0;
  bit chk_en = 1'b0;

  wb_spi_cfg_writer #(.CLK_DIV(D), .NUM_SS(NSS)) dut (
    .wb_clk_i (clk),    .wb_rst_ni (rst_n), .wb_cyc_i (cyc),  .wb_stb_i (stb),
    .wb_we_i  (we),     .wb_adr_i  (adr),   .wb_sel_i (sel),  .wb_dat_i (dat_w),
    .wb_dat_o (dat_r),  .wb_ack_o  (ack),   .sclk_o   (sclk), .mosi_o   (mosi),
    .miso_i   (miso),   .ss_n_o    (ss_n),  .busy_o   (busy)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc_no);
    end
  endtask

  function automatic int nfix(input int v);
    return (v == 0 || v > 32) ? 32 : v;
  endfunction

  function automatic logic [31:0] lowmask(input int n);
    logic [63:0] m;
    m = (64'd1 << n) - 64'd1;
    return m[31:0];
  endfunction

  // Reference model: register contents plus one frame described by its start and length.
  bit          m_act, m_ack, m_rdflag, m_req, m_acc, m_st;
  int          m_rel, m_n;
  logic [31:0] m_tx, m_pat, m_txr, m_rx, m_dat, m_rd, next_pat;
  logic [7:0]  m_mk, m_ss;
  logic [5:0]  m_nb;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_act = 0; m_ack = 0; m_rdflag = 0; m_rel = 0; m_n = 32;
      m_nb = '0; m_ss = '0; m_txr = '0; m_rx = '0; m_dat = '0;
    end else begin
      m_req = cyc && stb && !m_ack;
      m_acc = m_req && !(we && adr[3:2] == 2'd1 && m_act);
      m_st  = 0;
      m_rd  = '0;
      if (m_acc && !we) begin
        case (adr[3:2])
          2'd0:    m_rd = {16'h0, m_ss, 2'b00, m_nb};
          2'd2:    m_rd = m_rx;
          2'd3:    m_rd = {31'd0, m_act};
          default: m_rd = '0;
        endcase
      end
      if (m_acc && we) begin
        if (adr[3:2] == 2'd0) begin
          if (sel[0]) m_nb = dat_w[5:0];
          if (sel[1]) m_ss = dat_w[15:8];
        end
        if (adr[3:2] == 2'd1) begin
          for (int b = 0; b < 4; b++) if (sel[b]) m_txr[8*b +: 8] = dat_w[8*b +: 8];
          m_st = |sel;
        end
      end
      if (m_act) begin
        m_rel++;
        if (m_rel == D * (2 * m_n + 1)) begin
          m_act = 0;
          m_rx  = m_pat & lowmask(m_n);
        end
      end
      if (m_st) begin
        m_act = 1; m_rel = 0; m_n = nfix(int'(m_nb));
        m_tx = m_txr; m_mk = m_ss; m_pat = next_pat;
      end
      m_ack = m_acc; m_rdflag = m_acc && !we; m_dat = m_rd;
    end
  end

  // Present the pattern bit that the next sclk rise must capture; random elsewhere.
  int mr;
  initial forever begin
    @(negedge clk); #1;
    miso = 1'($urandom_range(1, 0));
    if (m_act) begin
      mr = (m_rel < D) ? 0 : (m_rel - D) / (2 * D) + 1;
      if (mr < m_n) miso = m_pat[m_n - 1 - mr];
    end
  end

  // Per-cycle compare plus sclk-rise bookkeeping for the directed literals.
  int          rises, busy_cyc, kk, ii;
  logic [31:0] mcap;
  logic        sclk_q = 1'b0;
  logic        e_sclk, e_mosi, mosi_ok;
  logic [7:0]  e_ss;
  initial forever begin
    @(negedge clk);
    cyc_no++;
    if (chk_en && rst_n) begin
      e_sclk  = m_act && m_rel >= D && ((m_rel - D) / D) % 2 == 0;
      e_ss    = m_act ? ~m_mk : 8'hFF;
      mosi_ok = 1'b0;
      e_mosi  = 1'b0;
      if (m_act) begin
        if (m_rel < D) begin
          e_mosi = m_tx[m_n - 1]; mosi_ok = 1'b1;
        end else begin
          kk = (m_rel - D) / D; ii = kk / 2;
          if (kk % 2 == 0) begin
            e_mosi = m_tx[m_n - 1 - ii]; mosi_ok = 1'b1;
          end else if (ii + 1 < m_n) begin
            e_mosi = m_tx[m_n - 2 - ii]; mosi_ok = 1'b1;
          end
        end
      end
      check("ack", 32'(ack), 32'(m_ack));
      if (m_ack && m_rdflag) check("rdata", dat_r, m_dat);
      check("busy", 32'(busy), 32'(m_act));
      check("sclk", 32'(sclk), 32'(e_sclk));
      check("ss_n", 32'(ss_n), 32'(e_ss));
      if (mosi_ok) check("mosi", 32'(mosi), 32'(e_mosi));
    end
    if (sclk && !sclk_q) begin
      rises++;
      mcap = {mcap[30:0], mosi};
    end
    sclk_q = sclk;
    if (busy) busy_cyc++;
  end

  task automatic wb(input bit w, input logic [1:0] a, input logic [31:0] d,
                    input logic [3:0] s, output logic [31:0] rd);
    int t;
    @(negedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = {12'h000, a, 2'b00}; dat_w = d; sel = s;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!ack && t < 2000);
    if (!ack) begin
      checks++; errors++;
      $display("FAIL wb_ack_timeout: got no ack, expected ack within 2000 cycles");
    end
    rd = dat_r;
    #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 5000) begin
      @(negedge clk);
      t++;
    end
    #1;
    if (busy) begin
      checks++; errors++;
      $display("FAIL busy_timeout: got busy=1, expected 0 within 5000 cycles");
    end
  endtask

  task automatic frame_prep(input logic [31:0] pat);
    next_pat = pat; rises = 0; mcap = '0; busy_cyc = 0;
  endtask

  logic [31:0] rd;
  int          a1, a2, op;
  initial begin
    next_pat = '0; rises = 0; mcap = '0; busy_cyc = 0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_ack", 32'(ack), 0);
    check("rst_dat", dat_r, 0);
    check("rst_sclk", 32'(sclk), 0);
    check("rst_mosi", 32'(mosi), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ss_n", 32'(ss_n), 32'hFF);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    wb(0, 2'd3, 0, 4'hF, rd); check("rst_status", rd, 0);
    wb(0, 2'd0, 0, 4'hF, rd); check("rst_ctrl", rd, 0);

    // 8-bit frame, select 0 only
    wb(1, 2'd0, 32'h0000_0108, 4'hF, rd);
    frame_prep(32'h3C);
    wb(1, 2'd1, 32'h0000_00A5, 4'hF, rd);
    wait_idle();
    check("f8_rises", rises, 8);
    check("f8_mosi_bits", mcap, 32'hA5);
    check("f8_busy_len", busy_cyc, 34);
    wb(0, 2'd2, 0, 4'hF, rd); check("f8_rx", rd, 32'h3C);

    // back-to-back TX writes: second ack only once the first frame ends
    frame_prep(32'h5A);
    wb(1, 2'd1, 32'h0000_00C3, 4'hF, rd);
    a1 = cyc_no;
    repeat (2) @(negedge clk);
    wb(1, 2'd1, 32'h0000_0011, 4'hF, rd);
    a2 = cyc_no;
    check("b2b_ack_gap", a2 - a1, 35);
    wait_idle();

    // nbits 0 and 40 both mean 32
    wb(1, 2'd0, 32'h0000_0100, 4'hF, rd);
    frame_prep($urandom);
    wb(1, 2'd1, 32'h8000_0001, 4'hF, rd);
    wait_idle();
    check("n0_rises", rises, 32);
    check("n0_mosi_bits", mcap, 32'h8000_0001);
    wb(1, 2'd0, 32'h0000_0128, 4'hF, rd);
    frame_prep(32'hDEAD_BEEF);
    wb(1, 2'd1, 32'h8000_0001, 4'hF, rd);
    wait_idle();
    check("n40_rises", rises, 32);
    wb(0, 2'd2, 0, 4'hF, rd); check("n40_rx", rd, 32'hDEAD_BEEF);

    // reset in the middle of bit 4
    wb(1, 2'd0, 32'h0000_0308, 4'hF, rd);
    frame_prep(32'h99);
    wb(1, 2'd1, 32'h0000_005A, 4'hF, rd);
    repeat (18) @(negedge clk);
    #1;
    check("pre_rst_sclk", 32'(sclk), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ss_n", 32'(ss_n), 32'hFF);
    check("mid_rst_sclk", 32'(sclk), 0);
    check("mid_rst_busy", 32'(busy), 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    wb(0, 2'd3, 0, 4'hF, rd); check("post_rst_status", rd, 0);
    wb(0, 2'd2, 0, 4'hF, rd); check("post_rst_rx", rd, 0);

    // byte lanes, empty select mask, CTRL write during a frame
    wb(1, 2'd0, 32'hFFFF_FF10, 4'b0001, rd);
    wb(0, 2'd0, 0, 4'hF, rd); check("lane_ctrl", rd, 32'h10);
    frame_prep(32'h1357);
    wb(1, 2'd1, 32'h0000_1234, 4'hF, rd);
    wait_idle();
    check("mask0_rises", rises, 16);
    wb(1, 2'd0, 32'h0000_0208, 4'b0011, rd);
    frame_prep(32'h0F);
    wb(1, 2'd1, 32'h0000_0077, 4'hF, rd);
    wb(1, 2'd0, 32'h0000_FF04, 4'hF, rd);
    repeat (3) @(negedge clk);
    #1;
    check("busy_ctrl_ss_n", 32'(ss_n), 32'hFD);
    wait_idle();
    check("busy_ctrl_rises", rises, 8);
    wb(0, 2'd0, 0, 4'hF, rd); check("busy_ctrl_read", rd, 32'h0000_FF04);

    // random traffic checked cycle by cycle against the model
    for (int k = 0; k < 40; k++) begin
      op = $urandom_range(5, 0);
      case (op)
        0: wb(1, 2'd0, $urandom, 4'($urandom_range(15, 0)), rd);
        1, 2: begin
          next_pat = $urandom;
          wb(1, 2'd1, $urandom, 4'($urandom_range(15, 0)), rd);
        end
        3: wb(0, 2'($urandom_range(3, 0)), $urandom, 4'hF, rd);
        4: wb(1, 2'($urandom_range(3, 2)), $urandom, 4'hF, rd);
        default: repeat ($urandom_range(40, 0)) @(negedge clk);
      endcase
    end
    wait_idle();
    wb(0, 2'd3, 0, 4'hF, rd); check("final_status", rd, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_spi_cfg_writer.md
Name: wb_spi_cfg_writer

Overview:
- Wishbone slave that sits directly downstream of wb_bus_writer on the bootstrap bus, alongside the output-pin slave.
- Turns each 32-bit configuration word written by the ROM-driven writer into an SPI write to a clock/synth chip, so boot-time clock configuration needs no CPU.
- Withholds wb_ack_o on a data write while a transfer is in flight, so the bus writer paces itself without polling.
- SPI mode 0 only (sclk idles low, MOSI updated on sclk fall, MISO sampled on sclk rise), MSB first.

Parameters:
- CLK_DIV, 4, wb_clk_i cycles per sclk half-period; legal range 1..255.
- NUM_SS, 8, number of active-low slave-select outputs; legal range 1..8.

Ports:
- wb_clk_i  in  1  bus/system clock, the only clock.
- wb_rst_ni  in  1  reset, asynchronous, active-low.
- wb_cyc_i  in  1  bus cycle.
- wb_stb_i  in  1  strobe.
- wb_we_i  in  1  write enable.
- wb_adr_i  in  16  byte address; only [3:2] decoded.
- wb_sel_i  in  4  byte lane selects.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data.
- wb_ack_o  out  1  acknowledge.
- sclk_o  out  1  SPI clock.
- mosi_o  out  1  SPI data out.
- miso_i  in  1  SPI data in; sampled without a synchroniser.
- ss_n_o  out  NUM_SS  slave selects, active low.
- busy_o  out  1  transfer in progress.

Behaviour:
- Reset (async, wb_rst_ni=0) forces every output immediately:
  - wb_ack_o=0, wb_dat_o=0, sclk_o=0, mosi_o=0, busy_o=0, ss_n_o all 1.
  - CTRL, TX and RX registers cleared; FSM to IDLE.
  - Applies in any state, including mid-transfer. No partial frame resumes after reset release.
- Register map (wb_adr_i[3:2]):
  - 0 = CTRL, read/write. [5:0] nbits; 0 or any value >32 means 32. [15:8] ss mask; only the low NUM_SS bits are used.
  - 1 = TX, write only; reads return 0.
  - 2 = RX, read only. Received bits right-aligned.
  - 3 = STATUS, read only. bit0 = busy.
  - Byte lanes honour wb_sel_i; unselected lanes keep their old value. Writes to read-only registers are acked and ignored.
- Ack rule:
  - Request = cyc&stb&!ack.
  - Ack is a 1-cycle registered pulse issued the cycle after the request is accepted. wb_ack_o is never high two cycles in a row.
  - Reads, CTRL writes and STATUS accesses are accepted the first request cycle.
  - A TX write while busy is held: no ack until busy drops, then accepted in the first cycle busy=0.
  - Read data is valid in the ack cycle.
- Transfer start:
  - Triggered by an accepted TX write with any sel bit set.
  - busy_o rises in the ack cycle.
  - nbits and ss mask are latched at start, so CTRL writes during busy affect the next frame only.
  - The word shifted is TX[n-1:0], starting with TX[n-1].
- FSM:
  - IDLE.
  - SETUP (CLK_DIV clocks): ss_n_o low for masked bits, sclk 0, mosi = first bit.
  - HIGH (CLK_DIV clocks): sclk 1; miso_i captured into the RX shift register on entry.
  - LOW (CLK_DIV clocks): sclk 0; mosi advances to the next bit.
  - Cycle HIGH→LOW n times. After the last LOW: ss_n_o all 1, busy 0, back to IDLE.
  - Busy duration = CLK_DIV*(2n+1) clocks.
  - RX is updated only at frame end; the RX register holds the previous frame until then.
- ss mask 0: frame still clocks, with no select asserted.
- Divider counter is 8 bits and reloads at each state change.

Decomposition:
- Package wb_spi_cfg_pkg: register offsets (CTRL/TX/RX/STATUS), FSM state encoding, and the nbits-normalise rule (0/>32 → 32).
- One sub-module spi_shift_core: divider plus FSM plus shift registers. Interface: start, nbits, ss_mask, tx, busy, rx, and the SPI pins.
- The top level holds the Wishbone decode, ack logic and registers.

Test Plan:
1. Reset values: CLK_DIV=2. Hold wb_rst_ni=0, then release → all outputs at reset values; STATUS reads 0, CTRL reads 0.
2. 8-bit frame: CTRL=0x0000_0108, TX=0xA5, miso tied to a pattern 0x3C → mosi shows 1,0,1,0,0,1,0,1 on sclk rises; 8 sclk pulses; ss_n_o=0xFE throughout; busy high 34 clocks; RX reads 0x3C.
3. Back-to-back: second TX write issued 3 cycles after the first ack → ack withheld until busy falls, then a single ack; second frame's SETUP begins with no gap cycle beyond acceptance.
4. nbits=0 and nbits=40 → 32 sclk pulses each; TX=0x8000_0001 yields first bit 1, last bit 1.
5. Mid-frame reset: assert wb_rst_ni low during bit 4 → ss_n_o all 1 and sclk 0 in the same cycle (async); after release, STATUS=0 and the next TX write runs a full frame.
6. Byte lanes: CTRL write 0xFFFF_FF10 with sel=0001 → CTRL reads 0x0000_0010; a subsequent CTRL write during busy does not change the current frame's ss_n_o.
